// File: rtl/gray_sync_decoder.sv
// Receiver for a Gray-coded bus from a foreign clock domain: synchronizes it,
// decodes to binary, and classifies each change as a +1/-1 step or an illegal jump.
module gray_sync_decoder #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N-1:0]         GrayIn,
  input  logic                 ClearErr,
  output logic [N-1:0]         GrayOut,
  output logic [N-1:0]         BinOut,
  output logic                 Valid,
  output logic                 Changed,
  output logic                 Up,
  output logic                 ErrPulse,
  output logic                 Error,
  output logic [ERR_CNT_W-1:0] ErrorCnt
);

  logic [SYNC_STAGES-1:0][N-1:0] syncQ;
  logic [SYNC_STAGES-1:0]        vldPipe;
  logic [N-1:0]                  prevGray;
  logic [N-1:0]                  bNew;
  logic [N-1:0]                  delta;
  logic                          isChange;
  logic                          stepUp;
  logic                          stepDn;
  logic                          isJump;

  // Plain flop chain, no logic between stages; the valid pipe flushes in step with it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      syncQ   <= '0;
      vldPipe <= '0;
    end else begin
      syncQ   <= {syncQ[SYNC_STAGES-2:0], GrayIn};
      vldPipe <= {vldPipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign GrayOut = syncQ[SYNC_STAGES-1];
  assign Valid   = vldPipe[SYNC_STAGES-1];

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign bNew[i] = ^GrayOut[N-1:i];
  end

  assign delta    = bNew - BinOut;
  assign isChange = GrayOut != prevGray;
  assign stepUp   = delta == N'(1);
  assign stepDn   = delta == '1;
  assign isJump   = isChange && !stepUp && !stepDn;

  // The new value is always accepted so tracking recovers after a jump.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prevGray <= '0;
      BinOut   <= '0;
      Changed  <= 1'b0;
      Up       <= 1'b0;
      ErrPulse <= 1'b0;
      Error    <= 1'b0;
      ErrorCnt <= '0;
    end else begin
      Changed  <= isChange;
      ErrPulse <= isJump;
      if (isChange) begin
        prevGray <= GrayOut;
        BinOut   <= bNew;
        if (stepUp)      Up <= 1'b1;
        else if (stepDn) Up <= 1'b0;
      end
      // A jump seen in the same cycle as a clear takes priority.
      if (isJump) begin
        Error <= 1'b1;
        if (ClearErr)             ErrorCnt <= ERR_CNT_W'(1);
        else if (ErrorCnt != '1)  ErrorCnt <= ErrorCnt + ERR_CNT_W'(1);
      end else if (ClearErr) begin
        Error    <= 1'b0;
        ErrorCnt <= '0;
      end
    end
  end

endmodule
